regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the MIPS datapath, the next generation of the single-cycle 32x32 file. Adds a configurable number of combinational read ports, two write ports with byte enables and a fixed priority, same-cycle write-to-read bypass, a hardwired zero register, and a per-register pending scoreboard so the pipelined core can detect load-use hazards. Sits between decode (read addresses, pending set) and writeback/memory-return (write ports).

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- ra  in  NRD*ADDR_W  read addresses; port k = ra[k*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data, port k packed the same way
- rd_busy  out  NRD  port k's register has a pending producer
- we0, we1  in  1  write enables; port 1 = memory-return path
- wa0, wa1  in  ADDR_W  write addresses
- wd0, wd1  in  DATA_W  write data
- wbe0, wbe1  in  DATA_W/8  byte enables, bit b covers byte b
- pend_set  in  1  mark pend_addr pending (producer issued)
- pend_addr  in  ADDR_W  register to mark

## Operation
- State: array regs[2**ADDR_W] of DATA_W; pending[2**ADDR_W] bits.
- Write: on edge with rst=1, for each byte b of register a: wd1 byte if we1&wbe1[b]&wa1==a, else wd0 byte if we0&wbe0[b]&wa0==a, else hold. Port 1 wins per byte on address collision.
- ZERO_REG=1: writes to address 0 discarded; regs[0] stays 0.
- Pending: on edge with rst=1, pending[a] cleared if any write port with we=1 and wbe≠0 targets a; then set if pend_set and pend_addr==a. Set wins over same-cycle clear. pend_set to 0 ignored when ZERO_REG=1.
- Read port k (combinational): per byte, bypass the value that would be written this edge (same priority as write), else regs[ra_k]. ZERO_REG=1 and ra_k==0 -> rd_k = 0.
- Bypass and busy-clear are suppressed while rst=0; rd then shows array contents.
- rd_busy[k] = pending[ra_k] & ~(a write port hits ra_k with we=1, wbe≠0 this cycle). Pending set this cycle is not visible until the next cycle.
- Partial byte write clears pending for the whole register.

## Timing
- Read latency 0 (combinational from ra, write ports, state).
- Write latency 1: regs visible through array the cycle after the edge; visible same cycle through bypass.
- Reset: edge with rst=0 zeroes all regs and pending; writes and pend_set on that edge ignored. Reset mid-write (rst low with we high) discards the write. After release, rd=0 and rd_busy=0 for all addresses.
- No handshakes; no stall inputs; every cycle accepts both writes and one pend_set.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst low one edge -> rd for r5 = 0x0, rd_busy=0 everywhere.
- Bypass: we0=1, wa0=7, wd0=0x12345678, wbe0=0xF, ra port0=7 same cycle -> rd0=0x12345678 before edge; after edge with we0=0 still 0x12345678.
- Collision/byte enables: r3=0xAAAAAAAA; we0 wa0=3 wd0=0x11111111 wbe0=0xF, we1 wa1=3 wd1=0x22222222 wbe1=0x3 -> r3=0x11112222.
- Zero register: we0 wa0=0 wd0=0xFFFFFFFF, pend_set addr 0 -> rd of r0 = 0, rd_busy=0.
- Scoreboard: pend_set addr 9 -> next cycle rd_busy=1 for ra=9; we1 wa1=9 wbe1=0x1 -> rd_busy=0 that cycle, byte 0 bypassed; following cycle pending[9]=0.
- Set vs clear: same cycle pend_set addr 4 and we0 wa0=4 -> next cycle rd_busy=1 for ra=4, r4 holds new data.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: decode-side read/pending signals plus the
// writeback and memory-return write ports.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
);
    localparam int unsigned NBYTE = DATA_W / 8;

    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rd_busy;

    logic                  we0;
    logic [ADDR_W-1:0]     wa0;
    logic [DATA_W-1:0]     wd0;
    logic [NBYTE-1:0]      wbe0;

    logic                  we1;
    logic [ADDR_W-1:0]     wa1;
    logic [DATA_W-1:0]     wd1;
    logic [NBYTE-1:0]      wbe1;

    logic                  pend_set;
    logic [ADDR_W-1:0]     pend_addr;

    // Core side: drives addresses, writes and pending marks.
    modport master (
        output ra, we0, wa0, wd0, wbe0, we1, wa1, wd1, wbe1, pend_set, pend_addr,
        input  rd, rd_busy
    );

    // Register-file side.
    modport slave (
        input  ra, we0, wa0, wd0, wbe0, we1, wa1, wd1, wbe1, pend_set, pend_addr,
        output rd, rd_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-enabled dual write, same-cycle bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic w_clr0;
    logic w_clr1;
    logic [NRD*DATA_W-1:0] w_rd;
    logic [NRD-1:0]        w_busy;

    // A write only retires a pending producer if it actually carries bytes.
    assign w_clr0 = bus.we0 && (|bus.wbe0);
    assign w_clr1 = bus.we1 && (|bus.wbe1);

    // Array and scoreboard update; port 1 is applied last so it wins per byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int b = 0; b < int'(NBYTE); b++) begin
                if (bus.we0 && bus.wbe0[b]) begin
                    r_regs[bus.wa0][b*8 +: 8] <= bus.wd0[b*8 +: 8];
                end
            end
            for (int b = 0; b < int'(NBYTE); b++) begin
                if (bus.we1 && bus.wbe1[b]) begin
                    r_regs[bus.wa1][b*8 +: 8] <= bus.wd1[b*8 +: 8];
                end
            end
            if (w_clr0) begin
                r_pend[bus.wa0] <= 1'b0;
            end
            if (w_clr1) begin
                r_pend[bus.wa1] <= 1'b0;
            end
            // A new producer outranks a write retiring the old one.
            if (bus.pend_set) begin
                r_pend[bus.pend_addr] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                r_regs[0] <= '0;
                r_pend[0] <= 1'b0;
            end
        end
    end

    // Read ports: array value overlaid per byte with this edge's write data.
    always_comb begin
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_val;
        logic              w_hit;
        w_rd   = '0;
        w_busy = '0;
        w_a    = '0;
        w_val  = '0;
        w_hit  = 1'b0;
        for (int k = 0; k < int'(NRD); k++) begin
            w_a   = bus.ra[k*ADDR_W +: ADDR_W];
            w_val = r_regs[w_a];
            if (rst) begin
                for (int b = 0; b < int'(NBYTE); b++) begin
                    if (bus.we1 && bus.wbe1[b] && (bus.wa1 == w_a)) begin
                        w_val[b*8 +: 8] = bus.wd1[b*8 +: 8];
                    end else if (bus.we0 && bus.wbe0[b] && (bus.wa0 == w_a)) begin
                        w_val[b*8 +: 8] = bus.wd0[b*8 +: 8];
                    end
                end
            end
            w_hit = rst && ((w_clr0 && (bus.wa0 == w_a)) || (w_clr1 && (bus.wa1 == w_a)));
            if ((ZERO_REG != 0) && (w_a == '0)) begin
                w_val = '0;
            end
            w_rd[k*DATA_W +: DATA_W] = w_val;
            w_busy[k]                = r_pend[w_a] && !w_hit;
        end
    end

    assign bus.rd      = w_rd;
    assign bus.rd_busy = w_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, then randomized traffic
// checked against a behavioural model through an expectation queue.
module tb_regfile_mp;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NRD    = 2;
    localparam int unsigned DEPTH  = 32;

    typedef struct {
        logic        rst;
        logic [4:0]  ra0, ra1;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wbe0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  wbe1;
        logic        ps;
        logic [4:0]  pa;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
    } vec_t;

    typedef struct {
        logic [31:0] e0, e1;
        logic [1:0]  eb;
        int          tag;
    } exp_t;

    logic clk;
    logic rst;
    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) rf ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    vec_t tbl[20];

    logic [31:0] m_regs [DEPTH];
    logic        m_pend [DEPTH];

    function automatic logic [31:0] mdl_read(input logic [4:0] a, input vec_t v);
        logic [31:0] r;
        r = m_regs[a];
        if (v.rst) begin
            for (int b = 0; b < 4; b++) begin
                if (v.we1 && v.wbe1[b] && v.wa1 == a) r[b*8 +: 8] = v.wd1[b*8 +: 8];
                else if (v.we0 && v.wbe0[b] && v.wa0 == a) r[b*8 +: 8] = v.wd0[b*8 +: 8];
            end
        end
        if (a == 5'd0) r = 32'h0;
        return r;
    endfunction

    function automatic logic mdl_busy(input logic [4:0] a, input vec_t v);
        logic hit;
        hit = v.rst && ((v.we0 && v.wbe0 != 4'h0 && v.wa0 == a) ||
                        (v.we1 && v.wbe1 != 4'h0 && v.wa1 == a));
        return m_pend[a] && !hit;
    endfunction

    task automatic mdl_edge(input vec_t v);
        logic [31:0] nv [DEPTH];
        logic        np [DEPTH];
        for (int a = 0; a < int'(DEPTH); a++) begin
            nv[a] = mdl_read(5'(a), v);
            np[a] = !mdl_busy(5'(a), v) ? 1'b0 : m_pend[a];
            if (!v.rst) begin
                nv[a] = 32'h0;
                np[a] = 1'b0;
            end else if (v.ps && v.pa == 5'(a) && a != 0) begin
                np[a] = 1'b1;
            end
        end
        for (int a = 0; a < int'(DEPTH); a++) begin
            m_regs[a] = nv[a];
            m_pend[a] = np[a];
        end
    endtask

    task automatic chk32(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        rf.ra        = {v.ra1, v.ra0};
        rf.we0       = v.we0;
        rf.wa0       = v.wa0;
        rf.wd0       = v.wd0;
        rf.wbe0      = v.wbe0;
        rf.we1       = v.we1;
        rf.wa1       = v.wa1;
        rf.wd1       = v.wd1;
        rf.wbe1      = v.wbe1;
        rf.pend_set  = v.ps;
        rf.pend_addr = v.pa;
    endtask

    // Drive one cycle, queue its expectations, compare before the edge, advance.
    task automatic do_cycle(input vec_t v, input int tag);
        exp_t e;
        exp_t got;
        drive(v);
        e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL queue step %0d: got empty expected entry", tag);
        end else begin
            got = exp_q.pop_front();
            chk32("rd0", got.tag, rf.rd[31:0], got.e0);
            chk32("rd1", got.tag, rf.rd[63:32], got.e1);
            chk32("busy", got.tag, 32'(rf.rd_busy), 32'(got.eb));
        end
        mdl_edge(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        //          rst ra0   ra1   we0 wa0   wd0           wbe0  we1 wa1   wd1           wbe1  ps pa    e0            e1            eb
        tbl[0]  = '{1, 5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 4'hF, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
        tbl[1]  = '{0, 5'd5, 5'd6, 1, 5'd5, 32'h12345678, 4'hF, 0, 5'd0, 32'h0,        4'h0, 1, 5'd6, 32'hDEADBEEF, 32'h0,        2'b00};
        tbl[2]  = '{1, 5'd5, 5'd6, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        32'h0,        2'b00};
        tbl[3]  = '{1, 5'd7, 5'd5, 1, 5'd7, 32'h12345678, 4'hF, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h12345678, 32'h0,        2'b00};
        tbl[4]  = '{1, 5'd7, 5'd7, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h12345678, 32'h12345678, 2'b00};
        tbl[5]  = '{1, 5'd3, 5'd7, 1, 5'd3, 32'hAAAAAAAA, 4'hF, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'hAAAAAAAA, 32'h12345678, 2'b00};
        tbl[6]  = '{1, 5'd3, 5'd3, 1, 5'd3, 32'h11111111, 4'hF, 1, 5'd3, 32'h22222222, 4'h3, 0, 5'd0, 32'h11112222, 32'h11112222, 2'b00};
        tbl[7]  = '{1, 5'd3, 5'd3, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h11112222, 32'h11112222, 2'b00};
        tbl[8]  = '{1, 5'd3, 5'd3, 1, 5'd3, 32'hFFFFFFFF, 4'h0, 1, 5'd3, 32'hCAFEF00D, 4'h4, 0, 5'd0, 32'h11FE2222, 32'h11FE2222, 2'b00};
        tbl[9]  = '{1, 5'd0, 5'd3, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 0, 5'd0, 32'h0,        4'h0, 1, 5'd0, 32'h0,        32'h11FE2222, 2'b00};
        tbl[10] = '{1, 5'd0, 5'd9, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 1, 5'd9, 32'h0,        32'h0,        2'b00};
        tbl[11] = '{1, 5'd9, 5'd0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        32'h0,        2'b01};
        tbl[12] = '{1, 5'd9, 5'd9, 0, 5'd0, 32'h0,        4'h0, 1, 5'd9, 32'h000000AB, 4'h1, 0, 5'd0, 32'h000000AB, 32'h000000AB, 2'b00};
        tbl[13] = '{1, 5'd9, 5'd0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h000000AB, 32'h0,        2'b00};
        tbl[14] = '{1, 5'd4, 5'd4, 1, 5'd4, 32'h44444444, 4'hF, 0, 5'd0, 32'h0,        4'h0, 1, 5'd4, 32'h44444444, 32'h44444444, 2'b00};
        tbl[15] = '{1, 5'd4, 5'd4, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h44444444, 32'h44444444, 2'b11};
        tbl[16] = '{1, 5'd4, 5'd4, 1, 5'd4, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h44444444, 32'h44444444, 2'b11};
        tbl[17] = '{1, 5'd4, 5'd9, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h44444444, 32'h000000AB, 2'b01};
        tbl[18] = '{0, 5'd4, 5'd4, 0, 5'd0, 32'h0,        4'h0, 1, 5'd4, 32'h55555555, 4'hF, 0, 5'd0, 32'h44444444, 32'h44444444, 2'b11};
        tbl[19] = '{1, 5'd4, 5'd3, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        4'h0, 0, 5'd0, 32'h0,        32'h0,        2'b00};

        v = tbl[19];
        v.rst = 1'b0;
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < int'(DEPTH); a++) begin
            m_regs[a] = 32'h0;
            m_pend[a] = 1'b0;
        end

        for (int i = 0; i < 20; i++) begin
            do_cycle(tbl[i], i);
        end

        // Random traffic over a narrow address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            v.rst  = ($urandom_range(0, 39) != 0);
            v.ra0  = 5'($urandom_range(0, 7));
            v.ra1  = 5'($urandom_range(0, 7));
            v.we0  = 1'($urandom_range(0, 1));
            v.wa0  = 5'($urandom_range(0, 7));
            v.wd0  = $urandom;
            v.wbe0 = 4'($urandom_range(0, 15));
            v.we1  = 1'($urandom_range(0, 1));
            v.wa1  = 5'($urandom_range(0, 7));
            v.wd1  = $urandom;
            v.wbe1 = 4'($urandom_range(0, 15));
            v.ps   = 1'($urandom_range(0, 1));
            v.pa   = 5'($urandom_range(0, 7));
            v.e0   = mdl_read(v.ra0, v);
            v.e1   = mdl_read(v.ra1, v);
            v.eb   = {mdl_busy(v.ra1, v), mdl_busy(v.ra0, v)};
            do_cycle(v, 100 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
